// File: rtl/ariane_pkg.sv
// ariane_pkg: branch-prediction structures exchanged between resolution and the BHT.
package ariane_pkg;
    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic                   taken;
    } bht_update_t;
    typedef struct packed {
        logic                   valid;
        logic                   is_cbranch;
        logic [riscv::VLEN-1:0] pc;
        logic                   taken;
        logic                   pred_taken;
    } bht_resolve_t;
endpackage

// File: rtl/riscv.sv
// riscv: architectural widths shared by the front-end blocks.
package riscv;
    localparam int unsigned VLEN = 64;
endpackage

// File: rtl/mpush_fifo.sv
// mpush_fifo: circular buffer taking up to NR_PORTS in-order pushes and one pop per cycle.
module mpush_fifo #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NR_PORTS = 2,
    parameter type         dtype_t  = logic
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [NR_PORTS-1:0]  push_i,
    input  dtype_t               data_i [NR_PORTS],
    input  logic                 pop_i,
    output dtype_t               data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                 ready_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    dtype_t        mem_q [DEPTH];
    dtype_t        mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]   count_q, count_d;
    assign ready_o = count_q <= (PW+1)'(DEPTH - NR_PORTS);
    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;
    // Pushing ports are packed back to back so the queue never holds holes.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        count_d = count_q - (PW+1)'(pop_i);
        rd_d    = rd_q + PW'(pop_i);
        for (int i = 0; i < NR_PORTS; i++) begin
            if (push_i[i]) begin
                mem_d[wr_d] = data_i[i];
                wr_d        = wr_d + PW'(1);
                count_d     = count_d + (PW+1)'(1);
            end
        end
    end
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i || flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/bht_update_queue.sv
// bht_update_queue: funnels resolved conditional branches into one BHT update per cycle,
// with flush/debug suppression and update/mispredict counters.
module bht_update_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NR_PORTS  = 2,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic                                 debug_mode_i,
    input  logic [NR_PORTS-1:0]                  res_valid_i,
    input  logic [NR_PORTS-1:0]                  res_is_cbranch_i,
    input  logic [NR_PORTS-1:0][riscv::VLEN-1:0] res_pc_i,
    input  logic [NR_PORTS-1:0]                  res_taken_i,
    input  logic [NR_PORTS-1:0]                  res_pred_taken_i,
    output logic                                 res_ready_o,
    output bht_update_t                          bht_update_o,
    output logic [CNT_WIDTH-1:0]                 upd_cnt_o,
    output logic [CNT_WIDTH-1:0]                 mispred_cnt_o
);
    typedef struct packed {
        logic [riscv::VLEN-1:0] pc;
        logic                   taken;
    } entry_t;
    bht_resolve_t          res [NR_PORTS];
    entry_t                wdata [NR_PORTS];
    entry_t                head;
    logic [NR_PORTS-1:0]   push;
    logic [$clog2(DEPTH):0] count;
    logic                  pop;
    logic [CNT_WIDTH-1:0]  upd_cnt_q, upd_cnt_d, mispred_cnt_q, mispred_cnt_d;
    for (genvar g = 0; g < NR_PORTS; g++) begin : g_port
        assign res[g]   = '{valid: res_valid_i[g], is_cbranch: res_is_cbranch_i[g], pc: res_pc_i[g],
                            taken: res_taken_i[g], pred_taken: res_pred_taken_i[g]};
        assign push[g]  = res[g].valid & res[g].is_cbranch & res_ready_o & ~debug_mode_i & ~flush_i;
        assign wdata[g] = '{pc: res[g].pc, taken: res[g].taken};
    end
    mpush_fifo #(
        .DEPTH   (DEPTH),
        .NR_PORTS(NR_PORTS),
        .dtype_t (entry_t)
    ) i_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .flush_i(flush_i),
        .push_i (push),
        .data_i (wdata),
        .pop_i  (pop),
        .data_o (head),
        .count_o(count),
        .ready_o(res_ready_o)
    );
    // The BHT always accepts, so every visible update is also a pop.
    assign pop           = (count != '0) & ~flush_i;
    assign bht_update_o  = '{valid: pop, pc: head.pc, taken: head.taken};
    assign upd_cnt_o     = upd_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
    assign upd_cnt_d     = upd_cnt_q + CNT_WIDTH'(pop);
    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        for (int i = 0; i < NR_PORTS; i++)
            mispred_cnt_d = mispred_cnt_d + CNT_WIDTH'(push[i] & (res[i].taken ^ res[i].pred_taken));
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            upd_cnt_q     <= upd_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
    // A branch that would be stored but finds the queue not ready is silently lost.
    assert property (@(posedge clk_i) disable iff (rst_i)
        (|(res_valid_i & res_is_cbranch_i) && !debug_mode_i && !flush_i) |-> res_ready_o);
endmodule

// File: tb/tb_bht_update_queue.sv
// tb_bht_update_queue: directed and random traffic checked against a queue-based reference.
module tb_bht_update_queue;
    import ariane_pkg::*;
    localparam int DEPTH = 4;
    logic clk = 0, rst = 1, flush = 0, dbg = 0;
    logic [1:0] v = '0, cb = '0, tk = '0, pt = '0;
    logic [1:0][63:0] pc = '0;
    logic ready;
    bht_update_t upd;
    logic [31:0] upd_cnt, mis_cnt;
    typedef struct {logic [63:0] pc; logic taken;} ent_t;
    ent_t q[$];
    logic [31:0] m_upd = 0, m_mis = 0;
    int compared = 0, mismatched = 0;
    always #5 clk = ~clk;
    bht_update_queue #(.DEPTH(DEPTH), .NR_PORTS(2), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(dbg),
        .res_valid_i(v), .res_is_cbranch_i(cb), .res_pc_i(pc), .res_taken_i(tk),
        .res_pred_taken_i(pt), .res_ready_o(ready), .bht_update_o(upd),
        .upd_cnt_o(upd_cnt), .mispred_cnt_o(mis_cnt)
    );
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step();
        logic m_ready, m_valid;
        @(negedge clk);
        m_ready = q.size() <= DEPTH - 2;
        m_valid = q.size() != 0 && !flush;
        chk("ready", ready, m_ready);
        chk("valid", upd.valid, m_valid);
        if (m_valid) begin
            chk("pc", upd.pc, q[0].pc);
            chk("taken", upd.taken, q[0].taken);
        end
        chk("upd_cnt", upd_cnt, m_upd);
        chk("mispred_cnt", mis_cnt, m_mis);
        if (rst) begin
            q.delete();
            m_upd = 0;
            m_mis = 0;
        end else if (flush) q.delete();
        else begin
            if (m_valid) begin
                void'(q.pop_front());
                m_upd++;
            end
            for (int i = 0; i < 2; i++)
                if (v[i] && cb[i] && m_ready && !dbg) begin
                    q.push_back('{pc[i], tk[i]});
                    if (tk[i] != pt[i]) m_mis++;
                end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic port(int i, logic [63:0] a, logic t, logic p, logic c = 1'b1);
        v[i] = 1'b1; cb[i] = c; pc[i] = a; tk[i] = t; pt[i] = p;
    endtask
    task automatic idle();
        v = '0; cb = '0; flush = 0; dbg = 0; rst = 0;
    endtask
    initial begin
        @(posedge clk);
        #1;
        step();
        idle(); step();
        port(0, 64'h8000_0010, 1, 1); step();
        idle(); step(); step();
        port(0, 64'h100, 0, 1); port(1, 64'h104, 1, 1); step();
        idle(); repeat (3) step();
        for (int k = 0; k < 10; k++) begin
            idle();
            if (q.size() <= DEPTH - 2) begin
                port(0, 64'h1000 + 64'(k * 8), k[0], 0);
                port(1, 64'h1004 + 64'(k * 8), 1, 0);
            end
            step();
        end
        idle(); repeat (5) step();
        port(0, 64'h200, 1, 0); port(1, 64'h204, 0, 0); step();
        port(0, 64'h208, 1, 1); port(1, 64'h20c, 0, 0); step();
        flush = 1; port(0, 64'hdead0, 1, 0); port(1, 64'hdead4, 1, 0); step();
        idle(); step(); step();
        port(0, 64'h300, 1, 1); port(1, 64'h304, 0, 0); step();
        dbg = 1; port(0, 64'hbad0, 1, 0); port(1, 64'hbad4, 1, 0, 0); step();
        v = '0; step(); step();
        idle(); port(1, 64'h400, 0, 1, 0); step();
        idle(); port(0, 64'h500, 1, 0); port(1, 64'h504, 1, 0); step();
        idle(); rst = 1; step();
        idle(); step(); step();
        for (int k = 0; k < 400; k++) begin
            idle();
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            dbg   = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 2; i++) begin
                v[i]  = 1'($urandom_range(0, 1));
                cb[i] = ($urandom_range(0, 3) != 0);
                pc[i] = {$urandom, $urandom};
                tk[i] = 1'($urandom_range(0, 1));
                pt[i] = 1'($urandom_range(0, 1));
                if (q.size() > DEPTH - 2 && !flush && !dbg) cb[i] = 1'b0;
            end
            step();
        end
        idle(); repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
